// File: rtl/win3x3_stream_former.sv
// 3x3 sliding-window former for a raster pixel stream.
// Two line buffers hold the previous two lines. Each accepted pixel forms a new
// column {row-2, row-1, row}. That column is shifted into a 3x3 tap register.
// The register is presented as a window only when all nine taps belong to the
// current neighbourhood (row >= 2 and col >= 2).
module win3x3_stream_former #(
  parameter int unsigned DW    = 8,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  localparam int unsigned CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int unsigned RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [RW-1:0]   win_row,
  output logic [CW-1:0]   win_col,
  output logic            frame_done
);

  // lb_a_q holds line row-1 and lb_b_q holds line row-2, both indexed by column.
  // They have no reset: a tap is read only after two full lines have rewritten it.
  logic [DW-1:0] lb_a_q [IMG_W];
  logic [DW-1:0] lb_b_q [IMG_W];

  // Tap k = 3*r + c. Column c=2 is the newest column.
  logic [DW-1:0] tap_q [9];

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;
  logic          frame_done_q;

  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          emit;
  logic [DW-1:0] col_top;
  logic [DW-1:0] col_mid;

  // Single output stage: upstream may advance whenever the window slot is free
  // or is being drained in this same cycle.
  assign s_ready  = !win_valid_q || win_ready;
  assign accept   = s_valid && s_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
  assign col_top  = lb_b_q[col_q];
  assign col_mid  = lb_a_q[col_q];

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Line buffer update: row-1 moves down to row-2, and the new pixel becomes row-1.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_b_q[col_q] <= lb_a_q[col_q];
      lb_a_q[col_q] <= s_data;
    end
  end

  // Counters, the tap shift register and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= accept && col_last && row_last;
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          tap_q[3*r]     <= tap_q[3*r + 1];
          tap_q[3*r + 1] <= tap_q[3*r + 2];
        end
        tap_q[2] <= col_top;
        tap_q[5] <= col_mid;
        tap_q[8] <= s_data;
      end
      // A new window takes priority over the drain of the old one in the same cycle.
      if (emit) begin
        win_valid_q <= 1'b1;
        win_row_q   <= row_q;
        win_col_q   <= col_q;
      end else if (win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  // Flatten the taps onto the window bus.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < 9; k++) begin
      win_data[k*DW +: DW] = tap_q[k];
    end
  end

  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_win3x3_stream_former.sv
// Directed bench for win3x3_stream_former on a 4x4 image.
module tb_win3x3_stream_former;

  localparam int unsigned DW    = 8;
  localparam int unsigned IMG_W = 4;
  localparam int unsigned IMG_H = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          win_valid;
  logic          win_ready = 1'b1;
  logic [71:0]   win_data;
  logic [1:0]    win_row;
  logic [1:0]    win_col;
  logic          frame_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_frame_done = 0;
  int unsigned ready_mode = 0;  // 0: ready high, 1: ready low, 2: random

  logic [71:0] got_data [$];
  int unsigned got_row [$];
  int unsigned got_col [$];
  logic [71:0] exp_data [$];
  int unsigned exp_row [$];
  int unsigned exp_col [$];

  // Hand-computed taps of the four windows of a 0..15 frame.
  int unsigned win_tab [4][9] = '{
    '{0, 1, 2, 4, 5, 6, 8,  9,  10},
    '{1, 2, 3, 5, 6, 7, 9,  10, 11},
    '{4, 5, 6, 8, 9, 10, 12, 13, 14},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15}
  };
  int unsigned win_tab_row [4] = '{2, 2, 3, 3};
  int unsigned win_tab_col [4] = '{2, 3, 2, 3};

  win3x3_stream_former #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .win_row    (win_row),
    .win_col    (win_col),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive win_ready just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       win_ready = 1'b1;
      1:       win_ready = 1'b0;
      default: win_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Record every window handshake and every frame_done pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) begin
      got_data.push_back(win_data);
      got_row.push_back(int'(win_row));
      got_col.push_back(int'(win_col));
    end
    if (rst_n && frame_done) n_frame_done++;
  end

  task automatic clear_scoreboard();
    got_data.delete();
    got_row.delete();
    got_col.delete();
    exp_data.delete();
    exp_row.delete();
    exp_col.delete();
    n_frame_done = 0;
  endtask

  task automatic expect_frame(input int unsigned base);
    logic [71:0] d;
    for (int w = 0; w < 4; w++) begin
      d = '0;
      for (int k = 0; k < 9; k++) d[k*8 +: 8] = 8'(win_tab[w][k] + base);
      exp_data.push_back(d);
      exp_row.push_back(win_tab_row[w]);
      exp_col.push_back(win_tab_col[w]);
    end
  endtask

  task automatic compare_windows(input string tag);
    int unsigned n;
    check({tag, "_count"}, 72'(got_data.size()), 72'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < int'(n); i++) begin
      check($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      check($sformatf("%s_row%0d", tag, i), 72'(got_row[i]), 72'(exp_row[i]));
      check($sformatf("%s_col%0d", tag, i), 72'(got_col[i]), 72'(exp_col[i]));
    end
  endtask

  // Present one pixel and return at 1 time unit after the edge that accepts it.
  task automatic send_pixel(input logic [7:0] v);
    int unsigned waited = 0;
    s_valid = 1'b1;
    s_data  = v;
    do begin
      @(negedge clk);
      waited++;
    end while (!s_ready && waited < 1000);
    if (!s_ready) check("send_timeout", 72'(s_ready), 72'(1));
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input int unsigned base, input bit gaps);
    for (int p = 0; p < 16; p++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          @(posedge clk);
          #1;
        end
      end
      send_pixel(8'(base + p));
    end
  endtask

  // Reset asserted between edges; every output must read zero while it is held.
  task automatic apply_reset(input string tag);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    check({tag, "_win_valid"}, 72'(win_valid), 72'(0));
    check({tag, "_win_data"}, win_data, 72'(0));
    check({tag, "_win_row"}, 72'(win_row), 72'(0));
    check({tag, "_win_col"}, 72'(win_col), 72'(0));
    check({tag, "_frame_done"}, 72'(frame_done), 72'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_scoreboard();
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [71:0] first_win;
  logic        seen;

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    #2;
    apply_reset("rst");
    check("rst_s_ready", 72'(s_ready), 72'(1));

    // Gap-free frame with per-pixel latency and frame_done timing.
    clear_scoreboard();
    expect_frame(0);
    for (int p = 0; p < 16; p++) begin
      send_pixel(8'(p));
      check($sformatf("lat_valid_p%0d", p), 72'(win_valid),
            72'(((p / 4) >= 2) && ((p % 4) >= 2)));
      if ((p / 4) >= 2 && (p % 4) >= 2) begin
        check($sformatf("lat_tap8_p%0d", p), 72'(win_data[71:64]), 72'(p));
      end
      check($sformatf("fdone_p%0d", p), 72'(frame_done), 72'(p == 15));
    end
    drain();
    compare_windows("basic");
    check("basic_frame_done", 72'(n_frame_done), 72'(1));

    // Backpressure after the first window.
    apply_reset("rst_bp");
    expect_frame(0);
    ready_mode = 1;
    @(posedge clk);
    #1;
    fork
      send_frame(0, 1'b0);
      begin
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
          @(negedge clk);
          seen = win_valid;
        end
        check("bp_first_valid", 72'(win_valid), 72'(1));
        first_win = win_data;
        check("bp_first_data", first_win, exp_data[0]);
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check($sformatf("bp_s_ready%0d", i), 72'(s_ready), 72'(0));
          check($sformatf("bp_hold%0d", i), win_data, first_win);
        end
        ready_mode = 0;
      end
    join
    drain();
    compare_windows("bp");

    // Two frames back to back.
    apply_reset("rst_b2b");
    expect_frame(0);
    expect_frame(100);
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain();
    compare_windows("b2b");
    check("b2b_frame_done", 72'(n_frame_done), 72'(2));

    // Random input gaps and random downstream ready.
    apply_reset("rst_rand");
    expect_frame(0);
    ready_mode = 2;
    send_frame(0, 1'b1);
    ready_mode = 0;
    drain();
    compare_windows("rand");
    check("rand_frame_done", 72'(n_frame_done), 72'(1));

    // Reset in the middle of a frame, then a clean frame.
    apply_reset("rst_pre_mid");
    for (int p = 0; p < 8; p++) send_pixel(8'(p + 50));
    apply_reset("rst_mid");
    expect_frame(0);
    send_frame(0, 1'b0);
    drain();
    compare_windows("after_rst");
    check("after_rst_frame_done", 72'(n_frame_done), 72'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
